// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch stage. It requests one 16-bit instruction at a time from
//   instruction memory, latches it into IR and issues the decoded fields to the
//   downstream stage. It also handles downstream stall, branch redirect and a
//   sticky HALT.
//
// Handshakes:
//   imem_req/imem_ack : imem_req is held high with a stable imem_addr until
//                       imem_ack is seen on a rising edge. imem_rdata is
//                       captured on that edge. imem_ack is ignored while
//                       imem_req is low.
//   instr_valid/stall : stall acts as an inverted ready. An instruction is
//                       accepted on a rising edge where instr_valid=1 and
//                       stall=0. Until then every issued output holds steady.
//
// Ports:
//   clk, rst_n      system clock; asynchronous active-low reset
//   imem_req        instruction read request pending
//   imem_addr       fetch address (equals pc)
//   imem_ack        imem_rdata valid this cycle
//   imem_rdata      instruction word
//   stall           downstream cannot accept the issued instruction
//   branch_taken    redirect pc to branch_target when an issue is accepted
//   branch_target   redirect address
//   instr_valid     decoded fields are being issued
//   instr_type, opcode, rd, rs1, rs2, imm   fields decoded from IR
//   pc_out          address of the instruction held in IR
//   halted          a HALT instruction has been fetched
//   state_dbg       current FSM state (IDLE=0, REQ=1, ISSUE=2, HALT=3)
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter int          PC_W     = 8,
  parameter int unsigned RESET_PC = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [15:0]     imem_rdata,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_target,
  output logic            instr_valid,
  output logic [1:0]      instr_type,
  output logic [4:0]      opcode,
  output logic [2:0]      rd,
  output logic [2:0]      rs1,
  output logic [2:0]      rs2,
  output logic [5:0]      imm,
  output logic [PC_W-1:0] pc_out,
  output logic            halted,
  output logic [1:0]      state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    ISSUE = 2'd2,
    HALT  = 2'd3
  } state_t;

  localparam logic [PC_W-1:0] PC_INIT = PC_W'(RESET_PC);

  state_t          state, state_n;
  logic [PC_W-1:0] pc, pc_n;
  logic [PC_W-1:0] pc_q, pc_q_n;
  logic [15:0]     ir, ir_n;
  logic            is_halt;

  // HALT encoding: instr_type 2'b10 with opcode 5'b11111.
  assign is_halt = (imem_rdata[15:14] == 2'b10) && (imem_rdata[13:9] == 5'b11111);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pc    <= PC_INIT;
      pc_q  <= '0;
      ir    <= 16'h0000;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      pc_q  <= pc_q_n;
      ir    <= ir_n;
    end
  end

  always_comb begin
    state_n = state;
    pc_n    = pc;
    pc_q_n  = pc_q;
    ir_n    = ir;
    case (state)
      IDLE: state_n = REQ;
      REQ: begin
        if (imem_ack) begin
          ir_n    = imem_rdata;
          pc_q_n  = pc;
          pc_n    = pc + PC_W'(1);  // wraps modulo 2^PC_W
          state_n = is_halt ? HALT : ISSUE;
        end
      end
      ISSUE: begin
        // A branch only counts on the edge that accepts the instruction.
        // While stalled it is ignored and sampled again later.
        if (!stall) begin
          state_n = REQ;
          if (branch_taken) pc_n = branch_target;
        end
      end
      HALT: state_n = HALT;  // only reset leaves HALT
      default: state_n = IDLE;
    endcase
  end

  // All outputs are decoded from registered state. Asserting reset therefore
  // drops imem_req and instr_valid without waiting for a clock edge.
  assign imem_req    = (state == REQ);
  assign imem_addr   = pc;
  assign instr_valid = (state == ISSUE);
  assign halted      = (state == HALT);
  assign pc_out      = pc_q;
  assign state_dbg   = state;

  // Fields always follow IR. The consumer qualifies them with instr_valid.
  assign instr_type = ir[15:14];
  assign opcode     = ir[13:9];
  assign rd         = ir[8:6];
  assign rs1        = ir[5:3];
  assign rs2        = ir[2:0];
  assign imm        = ir[5:0];

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//   Bench for fetch_unit. Inputs are driven and outputs are sampled at the
//   falling edge. The reference model works at transaction level: it tracks
//   the address it expects to be fetched next and the word it handed back.
//   Expected fields are the raw bit slices of that word.
// -----------------------------------------------------------------------------
module tb_fetch_unit;
  localparam int        PC_W   = 8;
  localparam logic [7:0] RST_PC = 8'h00;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        stall;
  logic        branch_taken;
  logic [7:0]  branch_target;
  logic        instr_valid;
  logic [1:0]  instr_type;
  logic [4:0]  opcode;
  logic [2:0]  rd, rs1, rs2;
  logic [5:0]  imm;
  logic [7:0]  pc_out;
  logic        halted;
  logic [1:0]  state_dbg;

  int total = 0;
  int bad   = 0;

  // Clock and reset
  always #5 clk = ~clk;

  fetch_unit #(.PC_W(PC_W), .RESET_PC(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
    .instr_valid(instr_valid), .instr_type(instr_type), .opcode(opcode),
    .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .pc_out(pc_out), .halted(halted), .state_dbg(state_dbg)
  );

  // Driver tasks. Each one starts and ends just after a falling edge.
  task automatic idle_inputs();
    imem_ack = 1'b0; imem_rdata = 16'h0000; stall = 1'b0;
    branch_taken = 1'b0; branch_target = 8'h00;
  endtask

  // Ends in the first REQ cycle after reset release.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic give_ack(input logic [15:0] w);
    imem_ack = 1'b1; imem_rdata = w;
    @(negedge clk);
    imem_ack = 1'b0; imem_rdata = 16'($urandom);
  endtask

  task automatic accept(input logic br, input logic [7:0] tgt);
    stall = 1'b0; branch_taken = br; branch_target = tgt;
    @(negedge clk);
    branch_taken = 1'b0;
  endtask

  function automatic logic [15:0] rand_word();
    logic [15:0] w;
    w = 16'($urandom);
    if (w[15:9] == 7'b1011111) w[9] = 1'b0;  // never a HALT
    return w;
  endfunction

  // Scenario tasks
  task automatic test_reset();
    rst_n = 1'b0; idle_inputs();
    #12;
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%b exp=0", imem_req); end
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", instr_valid); end
    total++; if (halted !== 1'b0) begin bad++; $display("FAIL rst_halted got=%b exp=0", halted); end
    total++; if (pc_out !== 8'h00) begin bad++; $display("FAIL rst_pc_out got=%h exp=00", pc_out); end
    total++; if (imem_addr !== RST_PC) begin bad++; $display("FAIL rst_addr got=%h exp=%h", imem_addr, RST_PC); end
    total++; if ({instr_type, opcode, rd, rs1, rs2} !== 16'h0000 || imm !== 6'h00) begin
      bad++; $display("FAIL rst_fields got=%h exp=0000", {instr_type, opcode, rd, rs1, rs2}); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rst_idle_req got=%b exp=0", imem_req); end
    @(negedge clk);
    total++; if (imem_req !== 1'b1 || imem_addr !== RST_PC) begin
      bad++; $display("FAIL rst_first_req got=%b/%h exp=1/%h", imem_req, imem_addr, RST_PC); end
  endtask

  task automatic test_zero_wait();
    do_reset();
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL zw_early_valid got=%b exp=0", instr_valid); end
    give_ack(16'h0643);
    total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL zw_valid got=%b exp=1", instr_valid); end
    total++; if (instr_type !== 2'b00 || opcode !== 5'b00011 || rd !== 3'd1 || rs1 !== 3'd0 || rs2 !== 3'd3) begin
      bad++; $display("FAIL zw_fields got=%b_%b_%0d_%0d_%0d exp=00_00011_1_0_3", instr_type, opcode, rd, rs1, rs2); end
    total++; if (imm !== 6'b000011) begin bad++; $display("FAIL zw_imm got=%h exp=03", imm); end
    total++; if (pc_out !== 8'h00) begin bad++; $display("FAIL zw_pc_out got=%h exp=00", pc_out); end
    accept(1'b0, 8'h00);
    total++; if (imem_req !== 1'b1 || imem_addr !== 8'h01) begin
      bad++; $display("FAIL zw_next got=%b/%h exp=1/01", imem_req, imem_addr); end
  endtask

  task automatic test_stall();
    logic [15:0] w;
    do_reset();
    w = rand_word();
    give_ack(w);
    for (int i = 0; i < 5; i++) begin
      total++; if (instr_valid !== 1'b1 || {instr_type, opcode, rd, rs1, rs2} !== w || imm !== w[5:0]
                   || pc_out !== 8'h00 || imem_req !== 1'b0) begin
        bad++; $display("FAIL stall_hold[%0d] got=%b/%h/%h/%b exp=1/%h/00/0", i, instr_valid,
                        {instr_type, opcode, rd, rs1, rs2}, pc_out, imem_req, w); end
      stall = (i < 4);
      @(negedge clk);
    end
    total++; if (imem_req !== 1'b1 || imem_addr !== 8'h01) begin
      bad++; $display("FAIL stall_next got=%b/%h exp=1/01", imem_req, imem_addr); end
  endtask

  task automatic test_branch();
    logic [15:0] w;
    do_reset();
    w = rand_word();
    give_ack(w);
    accept(1'b1, 8'h05);
    total++; if (imem_addr !== 8'h05) begin bad++; $display("FAIL br_to5 got=%h exp=05", imem_addr); end
    give_ack(w);
    total++; if (pc_out !== 8'h05) begin bad++; $display("FAIL br_pc_out got=%h exp=05", pc_out); end
    stall = 1'b1; branch_taken = 1'b1; branch_target = 8'h20;
    @(negedge clk);
    total++; if (instr_valid !== 1'b1 || pc_out !== 8'h05) begin
      bad++; $display("FAIL br_stalled got=%b/%h exp=1/05", instr_valid, pc_out); end
    stall = 1'b0; branch_taken = 1'b0;
    @(negedge clk);
    total++; if (imem_addr !== 8'h06) begin bad++; $display("FAIL br_ignored got=%h exp=06", imem_addr); end
    give_ack(w);
    accept(1'b1, 8'h05);
    give_ack(w);
    accept(1'b1, 8'h20);
    total++; if (imem_req !== 1'b1 || imem_addr !== 8'h20) begin
      bad++; $display("FAIL br_taken got=%b/%h exp=1/20", imem_req, imem_addr); end
    give_ack(w);
    accept(1'b1, pc_out);  // self-loop
    total++; if (imem_addr !== 8'h20) begin bad++; $display("FAIL br_self got=%h exp=20", imem_addr); end
  endtask

  task automatic test_wrap();
    logic [15:0] w;
    w = rand_word();
    give_ack(w);
    accept(1'b1, 8'hFF);
    for (int i = 0; i < 4; i++) begin
      total++; if (imem_req !== 1'b1 || imem_addr !== 8'hFF) begin
        bad++; $display("FAIL wrap_hold[%0d] got=%b/%h exp=1/ff", i, imem_req, imem_addr); end
      if (i < 3) begin imem_ack = 1'b0; @(negedge clk); end
      else give_ack(w);
    end
    total++; if (instr_valid !== 1'b1 || pc_out !== 8'hFF) begin
      bad++; $display("FAIL wrap_issue got=%b/%h exp=1/ff", instr_valid, pc_out); end
    accept(1'b0, 8'h00);
    total++; if (imem_addr !== 8'h00) begin bad++; $display("FAIL wrap_next got=%h exp=00", imem_addr); end
  endtask

  task automatic test_halt();
    do_reset();
    give_ack(16'hBE00);
    total++; if (halted !== 1'b1 || instr_valid !== 1'b0 || imem_req !== 1'b0) begin
      bad++; $display("FAIL halt_enter got=%b/%b/%b exp=1/0/0", halted, instr_valid, imem_req); end
    for (int i = 0; i < 20; i++) begin
      imem_ack = 1'($urandom); stall = 1'($urandom);
      branch_taken = 1'($urandom); branch_target = 8'($urandom);
      @(negedge clk);
      total++; if (halted !== 1'b1 || instr_valid !== 1'b0 || imem_req !== 1'b0) begin
        bad++; $display("FAIL halt_stay[%0d] got=%b/%b/%b exp=1/0/0", i, halted, instr_valid, imem_req); end
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    logic [15:0] w;
    w = rand_word();
    do_reset();
    #2 rst_n = 1'b0;
    #1;
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rmid_req got=%b exp=0", imem_req); end
    @(negedge clk);
    imem_ack = 1'b1; imem_rdata = w;  // late ack held across release
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (imem_req !== 1'b1 || imem_addr !== RST_PC || instr_valid !== 1'b0) begin
      bad++; $display("FAIL rmid_refetch got=%b/%h/%b exp=1/%h/0", imem_req, imem_addr, instr_valid, RST_PC); end
    imem_ack = 1'b0;
    give_ack(w);
    total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL rmid_issue got=%b exp=1", instr_valid); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (instr_valid !== 1'b0 || pc_out !== 8'h00) begin
      bad++; $display("FAIL rmid_abort got=%b/%h exp=0/00", instr_valid, pc_out); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [7:0]  mpc;
    logic [15:0] w;
    logic        br;
    logic [7:0]  tgt;
    int          waits, nst;
    do_reset();
    mpc = RST_PC;
    for (int t = 0; t < 60; t++) begin
      w = rand_word();
      waits = $urandom_range(0, 3);
      nst   = $urandom_range(0, 2);
      total++; if (imem_req !== 1'b1 || imem_addr !== mpc) begin
        bad++; $display("FAIL rnd_req[%0d] got=%b/%h exp=1/%h", t, imem_req, imem_addr, mpc); end
      for (int k = 0; k < waits; k++) begin
        stall = 1'($urandom); branch_taken = 1'($urandom); branch_target = 8'($urandom);
        @(negedge clk);
        total++; if (imem_req !== 1'b1 || imem_addr !== mpc || instr_valid !== 1'b0) begin
          bad++; $display("FAIL rnd_wait[%0d] got=%b/%h exp=1/%h", t, imem_req, imem_addr, mpc); end
      end
      stall = 1'b0; branch_taken = 1'b0;
      give_ack(w);
      total++; if (instr_valid !== 1'b1 || {instr_type, opcode, rd, rs1, rs2} !== w || imm !== w[5:0]
                   || pc_out !== mpc) begin
        bad++; $display("FAIL rnd_issue[%0d] got=%b/%h/%h exp=1/%h/%h", t, instr_valid,
                        {instr_type, opcode, rd, rs1, rs2}, pc_out, w, mpc); end
      for (int k = 0; k < nst; k++) begin
        stall = 1'b1; branch_taken = 1'($urandom); branch_target = 8'($urandom);
        imem_ack = 1'($urandom); imem_rdata = 16'($urandom);
        @(negedge clk);
        imem_ack = 1'b0;
        total++; if (instr_valid !== 1'b1 || {instr_type, opcode, rd, rs1, rs2} !== w
                     || pc_out !== mpc || imem_req !== 1'b0) begin
          bad++; $display("FAIL rnd_stall[%0d] got=%b/%h/%h exp=1/%h/%h", t, instr_valid,
                          {instr_type, opcode, rd, rs1, rs2}, pc_out, w, mpc); end
      end
      br  = 1'($urandom);
      tgt = 8'($urandom);
      accept(br, tgt);
      mpc = br ? tgt : mpc + 8'd1;
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_stall();
    test_branch();
    test_wrap();
    test_halt();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter PC_W, default 8, meaning the program-counter and instruction-memory address width.
REQ-002 The block SHALL have parameter RESET_PC, default 0, meaning the first instruction address fetched after reset.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 The block SHALL have port clk, input, 1, meaning the system clock; all state updates occur on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1, meaning the asynchronous active-low reset.
REQ-006 The block SHALL have port imem_req, output, 1, meaning an instruction-read request is pending.
REQ-007 The block SHALL have port imem_addr, output, PC_W, meaning the instruction address, equal to pc.
REQ-008 The block SHALL have port imem_ack, input, 1, meaning imem_rdata is valid this cycle.
REQ-009 The block SHALL have port imem_rdata, input, 16, meaning the instruction word.
REQ-010 The block SHALL have port stall, input, 1, meaning the downstream stage cannot accept the issued instruction.
REQ-011 The block SHALL have port branch_taken, input, 1, meaning redirect the PC.
REQ-012 The block SHALL have port branch_target, input, PC_W, meaning the redirect address.
REQ-013 The block SHALL have port instr_valid, output, 1, meaning the decoded fields are being issued.
REQ-014 The block SHALL have ports instr_type, output, 2 (IR[15:14]); opcode, output, 5 (IR[13:9]); rd, output, 3 (IR[8:6]); rs1, output, 3 (IR[5:3]); rs2, output, 3 (IR[2:0]); imm, output, 6 (IR[5:0]).
REQ-015 The block SHALL have port pc_out, output, PC_W, meaning the address of the instruction currently held in IR.
REQ-016 The block SHALL have port halted, output, 1, meaning a HALT instruction has been fetched.

Function
REQ-017 The block SHALL implement the FSM states IDLE, REQ, ISSUE, and HALT.
REQ-018 The FSM SHALL move from IDLE to REQ unconditionally on the next clock edge.
REQ-019 In REQ, imem_req SHALL be 1 and imem_addr SHALL equal pc, held stable until imem_ack; the wait length is unbounded.
REQ-020 In REQ with imem_ack=1, the block SHALL load IR with imem_rdata and pc_out with pc, and set pc to pc+1 modulo 2^PC_W; for example, PC_W=8 wraps 0xFF to 0x00.
REQ-021 The FSM SHALL then enter HALT if imem_rdata[15:14]=2'b10 and imem_rdata[13:9]=5'b11111, and ISSUE otherwise.
REQ-022 imem_req SHALL be 0 in IDLE, ISSUE, and HALT; imem_ack outside REQ SHALL be ignored.
REQ-023 In ISSUE, instr_valid SHALL be 1 and the decoded outputs SHALL be stable; the latency from imem_ack to instr_valid is exactly 1 cycle.
REQ-024 In ISSUE with stall=1, the block SHALL remain in ISSUE with IR, pc, and the outputs unchanged.
REQ-025 In ISSUE with stall=0, the instruction is accepted and the FSM SHALL return to REQ; if branch_taken=1 in the same cycle, pc SHALL be set to branch_target, otherwise pc is kept.
REQ-026 branch_taken SHALL be ignored in every state and cycle other than ISSUE with stall=0; when branch_taken and stall are both high, stall wins and the branch is sampled again later.
REQ-027 A branch_target equal to pc_out SHALL be legal, giving a self-loop that re-fetches the same address.
REQ-028 The block SHALL set halted=1 in HALT, keep instr_valid=0 and imem_req=0, and leave HALT only through reset; the HALT instruction is never issued.
REQ-029 The decoded outputs SHALL always reflect IR, including outside ISSUE; the consumer SHALL qualify them with instr_valid.

Reset
REQ-030 While rst_n=0, state SHALL be IDLE, pc=RESET_PC, IR=16'h0000, pc_out=0, and imem_req, instr_valid, and halted SHALL all be 0.
REQ-031 Reset asserted mid-REQ or mid-ISSUE SHALL abort immediately, dropping imem_req and instr_valid asynchronously; a late imem_ack after reset release SHALL be ignored while in IDLE.
REQ-032 After rst_n deasserts, the first imem_req SHALL rise on the second rising clock edge, one cycle through IDLE.

Verification
REQ-033 Zero-wait fetch: with imem_ack tied to imem_req, rdata=16'h0643 at address 0 and stall=0 -> instr_valid at cycle 3 with instr_type=00, opcode=00011, rd=1, rs1=0, rs2=3, pc_out=0; the next imem_addr is 1.
REQ-034 Stall: stall held high for 4 ISSUE cycles -> instr_valid high for 5 cycles with all outputs unchanged, imem_req low throughout, and the next fetch address equal to pc_out+1.
REQ-035 Branch: in ISSUE with pc_out=5, drive branch_taken=1, branch_target=0x20, stall=0 -> the next imem_addr is 0x20; the same pulse with stall=1 -> ignored, and pc stays 6.
REQ-036 Wait states and wrap: imem_ack delayed 3 cycles at pc=0xFF -> imem_addr is held at 0xFF for 4 cycles, and the next fetch is at 0x00.
REQ-037 Halt: fetch 16'hBE00 -> halted=1 one cycle after ack, instr_valid is never asserted, and imem_req stays 0 for 20 cycles.
REQ-038 Reset mid-wait: assert rst_n=0 while in REQ -> imem_req=0 the same cycle; after release, the first fetch is at RESET_PC.
